// File: rtl/tl_a_pkg.sv
// Shared TileLink A-channel types and constants for the repeater slice.
package tl_a_pkg;

    // Field widths the beat struct is built from; the repeater's parameters
    // default to these and must agree with them.
    localparam int TL_ADDR_W = 28;
    localparam int TL_SRC_W  = 5;
    localparam int TL_SIZE_W = 3;
    localparam int TL_DATA_W = 32;
    localparam int TL_MASK_W = TL_DATA_W / 8;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;
    localparam logic [2:0] OP_ACQUIRE     = 3'd6;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           param;
        logic [TL_SIZE_W-1:0] size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_ADDR_W-1:0] address;
        logic [TL_MASK_W-1:0] mask;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_a_beat_t;

    localparam int TL_BEAT_W = $bits(tl_a_beat_t);

endpackage

// File: rtl/tl_beat_hold_reg.sv
// Width-generic load-enable register with synchronous clear.
module tl_beat_hold_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d, data_q;

    // Take the new value only when loaded; otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load) data_d = d;
    end

    // State register, cleared synchronously.
    always_ff @(posedge clock) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/tl_a_repeater.sv
// Single-entry TileLink A-channel repeater: captures a beat when the
// consumer asks for a repeat and re-presents it until released.
module tl_a_repeater
    import tl_a_pkg::*;
#(
    parameter int ADDR_W = TL_ADDR_W,
    parameter int SRC_W  = TL_SRC_W,
    parameter int SIZE_W = TL_SIZE_W,
    parameter int DATA_W = TL_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    // "repeat" is a reserved word, hence the suffix
    input  logic                repeat_req,

    input  logic                enq_valid,
    output logic                enq_ready,
    input  logic [2:0]          enq_opcode,
    input  logic [2:0]          enq_param,
    input  logic [SIZE_W-1:0]   enq_size,
    input  logic [SRC_W-1:0]    enq_source,
    input  logic [ADDR_W-1:0]   enq_address,
    input  logic [DATA_W/8-1:0] enq_mask,
    input  logic [DATA_W-1:0]   enq_data,
    input  logic                enq_corrupt,

    output logic                deq_valid,
    input  logic                deq_ready,
    output logic [2:0]          deq_opcode,
    output logic [2:0]          deq_param,
    output logic [SIZE_W-1:0]   deq_size,
    output logic [SRC_W-1:0]    deq_source,
    output logic [ADDR_W-1:0]   deq_address,
    output logic [DATA_W/8-1:0] deq_mask,
    output logic [DATA_W-1:0]   deq_data,
    output logic                deq_corrupt,

    output logic                full,
    output logic [DATA_W/8-1:0] saved_mask,
    output logic                proto_err
);

    tl_a_beat_t enq_beat, saved_beat, deq_beat;
    logic       full_d, full_q;
    logic       proto_err_d, proto_err_q;
    logic       capture;

    // Pack the upstream fields into one beat.
    always_comb begin
        enq_beat         = '0;
        enq_beat.opcode  = enq_opcode;
        enq_beat.param   = enq_param;
        enq_beat.size    = enq_size;
        enq_beat.source  = enq_source;
        enq_beat.address = enq_address;
        enq_beat.mask    = enq_mask;
        enq_beat.data    = enq_data;
        enq_beat.corrupt = enq_corrupt;
    end

    // Handshakes depend only on state and ready/valid, never on repeat_req.
    assign enq_ready = deq_ready & ~full_q;
    assign deq_valid = enq_valid | full_q;
    assign capture   = enq_valid & enq_ready & repeat_req;

    // Saved beat: written only on capture, kept through release so the
    // monitor sees a stable mask until the next capture.
    tl_beat_hold_reg #(.W(TL_BEAT_W)) u_hold (
        .clock (clock),
        .reset (reset),
        .load  (capture),
        .d     (enq_beat),
        .q     (saved_beat)
    );

    // Present the held beat when full, otherwise pass upstream straight through.
    always_comb begin
        deq_beat = full_q ? saved_beat : enq_beat;
    end

    assign deq_opcode  = deq_beat.opcode;
    assign deq_param   = deq_beat.param;
    assign deq_size    = deq_beat.size;
    assign deq_source  = deq_beat.source;
    assign deq_address = deq_beat.address;
    assign deq_mask    = deq_beat.mask;
    assign deq_data    = deq_beat.data;
    assign deq_corrupt = deq_beat.corrupt;

    // Next state: capture needs empty, release needs full, so they never collide.
    always_comb begin
        full_d      = full_q;
        proto_err_d = proto_err_q | (repeat_req & ~deq_valid);
        if (capture)
            full_d = 1'b1;
        else if (full_q & deq_ready & ~repeat_req)
            full_d = 1'b0;
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign full       = full_q;
    assign proto_err  = proto_err_q;
    assign saved_mask = saved_beat.mask;

endmodule

// File: tb/tb_tl_a_repeater.sv
// Directed bench for tl_a_repeater with a scoreboard of expected deq beats.
module tb_tl_a_repeater;

    logic        clock = 1'b0;
    logic        reset;
    logic        repeat_req;
    logic        enq_valid, enq_ready;
    logic [2:0]  enq_opcode, enq_param;
    logic [2:0]  enq_size;
    logic [4:0]  enq_source;
    logic [27:0] enq_address;
    logic [3:0]  enq_mask;
    logic [31:0] enq_data;
    logic        enq_corrupt;
    logic        deq_valid, deq_ready;
    logic [2:0]  deq_opcode, deq_param;
    logic [2:0]  deq_size;
    logic [4:0]  deq_source;
    logic [27:0] deq_address;
    logic [3:0]  deq_mask;
    logic [31:0] deq_data;
    logic        deq_corrupt;
    logic        full;
    logic [3:0]  saved_mask;
    logic        proto_err;

    int checks = 0;
    int errors = 0;
    logic [78:0] sb[$];

    always #5 clock = ~clock;

    tl_a_repeater dut (
        .clock(clock), .reset(reset), .repeat_req(repeat_req),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_opcode(enq_opcode), .enq_param(enq_param), .enq_size(enq_size),
        .enq_source(enq_source), .enq_address(enq_address), .enq_mask(enq_mask),
        .enq_data(enq_data), .enq_corrupt(enq_corrupt),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_opcode(deq_opcode), .deq_param(deq_param), .deq_size(deq_size),
        .deq_source(deq_source), .deq_address(deq_address), .deq_mask(deq_mask),
        .deq_data(deq_data), .deq_corrupt(deq_corrupt),
        .full(full), .saved_mask(saved_mask), .proto_err(proto_err)
    );

    function automatic logic [78:0] pk(input logic [2:0] opc, input logic [2:0] prm,
                                       input logic [2:0] sz, input logic [4:0] src,
                                       input logic [27:0] adr, input logic [3:0] msk,
                                       input logic [31:0] dat, input logic cor);
        return {opc, prm, sz, src, adr, msk, dat, cor};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a beat on enq and return its packed form.
    task automatic drive(input logic [2:0] opc, input logic [27:0] adr, input logic [3:0] msk,
                         input logic [31:0] dat, output logic [78:0] beat);
        enq_opcode = opc; enq_param = 3'd0; enq_size = 3'd2; enq_source = 5'd3;
        enq_address = adr; enq_mask = msk; enq_data = dat; enq_corrupt = 1'b0;
        beat = pk(opc, 3'd0, 3'd2, 5'd3, adr, msk, dat, 1'b0);
    endtask

    // Wait for the sampling point of the current cycle.
    task automatic to_neg();
        @(negedge clock);
    endtask

    // Score any accepted deq beat, then advance past the active edge.
    task automatic finish_cycle();
        logic [78:0] exp;
        if (deq_valid && deq_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_beat", 96'd1, 96'd0);
            end else begin
                exp = sb.pop_front();
                check("sb_beat", {deq_opcode, deq_param, deq_size, deq_source, deq_address,
                                  deq_mask, deq_data, deq_corrupt}, exp);
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [78:0] b;
        reset = 1'b1; repeat_req = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        drive(3'd0, 28'd0, 4'd0, 32'd0, b);
        repeat (2) begin to_neg(); finish_cycle(); end
        to_neg();
        check("rst_full", full, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_saved_mask", saved_mask, 0);
        check("rst_deq_valid", deq_valid, 0);
        finish_cycle();
        reset = 1'b0;

        // Pass-through
        drive(tl_a_pkg::OP_GET, 28'h0000100, 4'hF, 32'h0, b);
        enq_valid = 1'b1; deq_ready = 1'b1; repeat_req = 1'b0;
        sb.push_back(b);
        to_neg();
        check("pt_deq_address", deq_address, 28'h0000100);
        check("pt_enq_ready", enq_ready, 1);
        check("pt_deq_valid", deq_valid, 1);
        finish_cycle();
        check("pt_full", full, 0);

        // Capture and triple re-issue; enq changes to prove the held beat is shown
        drive(tl_a_pkg::OP_PUT_FULL, 28'h0000200, 4'hF, 32'hDEADBEEF, b);
        repeat_req = 1'b1;
        repeat (4) sb.push_back(b);
        to_neg();
        check("cap_enq_ready", enq_ready, 1);
        finish_cycle();
        check("cap_full", full, 1);
        drive(tl_a_pkg::OP_GET, 28'h0000300, 4'h1, 32'h12345678, b);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) repeat_req = 1'b0;
            to_neg();
            check("rep_enq_ready", enq_ready, 0);
            check("rep_deq_data", deq_data, 32'hDEADBEEF);
            finish_cycle();
            check("rep_full", full, (i == 2) ? 0 : 1);
        end
        enq_valid = 1'b0;
        to_neg();
        check("rel_saved_mask", saved_mask, 4'hF);
        check("rel_deq_valid", deq_valid, 0);
        finish_cycle();

        // Downstream stall while full
        drive(tl_a_pkg::OP_PUT_PARTIAL, 28'h0000400, 4'h3, 32'hCAFE0000, b);
        enq_valid = 1'b1; repeat_req = 1'b1; deq_ready = 1'b1;
        sb.push_back(b); sb.push_back(b);
        to_neg(); finish_cycle();
        drive(tl_a_pkg::OP_GET, 28'h0000500, 4'h8, 32'h55555555, b);
        deq_ready = 1'b0; repeat_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            check("stall_deq_valid", deq_valid, 1);
            check("stall_deq_data", deq_data, 32'hCAFE0000);
            check("stall_deq_mask", deq_mask, 4'h3);
            check("stall_enq_ready", enq_ready, 0);
            finish_cycle();
            check("stall_full", full, 1);
        end
        deq_ready = 1'b1;
        to_neg(); finish_cycle();
        check("stall_rel_full", full, 0);
        check("stall_saved_mask", saved_mask, 4'h3);

        // Empty stall with repeat: nothing captured
        deq_ready = 1'b0; repeat_req = 1'b1; enq_valid = 1'b1;
        to_neg();
        check("estall_enq_ready", enq_ready, 0);
        finish_cycle();
        check("estall_full", full, 0);
        check("estall_proto_err", proto_err, 0);
        check("estall_saved_mask", saved_mask, 4'h3);

        // Protocol error: repeat with nothing presented
        enq_valid = 1'b0; deq_ready = 1'b1; repeat_req = 1'b1;
        to_neg(); finish_cycle();
        check("perr_set", proto_err, 1);
        repeat_req = 1'b0;
        repeat (3) begin to_neg(); finish_cycle(); end
        check("perr_sticky", proto_err, 1);

        // Reset mid-hold
        drive(tl_a_pkg::OP_ARITH, 28'h0000600, 4'hC, 32'hA5A5A5A5, b);
        enq_valid = 1'b1; repeat_req = 1'b1;
        sb.push_back(b);
        to_neg(); finish_cycle();
        check("rh_full", full, 1);
        drive(tl_a_pkg::OP_GET, 28'h0000700, 4'h2, 32'h0BADF00D, b);
        deq_ready = 1'b0; repeat_req = 1'b0; reset = 1'b1;
        to_neg(); finish_cycle();
        reset = 1'b0;
        to_neg();
        check("rh_full_cleared", full, 0);
        check("rh_saved_mask", saved_mask, 0);
        check("rh_proto_err", proto_err, 0);
        check("rh_deq_data", deq_data, 32'h0BADF00D);
        check("rh_deq_address", deq_address, 28'h0000700);
        finish_cycle();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
